// File: rtl/register_pkg.sv
// register_pkg: shared definitions for the loadable word register.
//   DEFAULT_WIDTH - word width used when the register is not overridden.
//   word_t        - word type at the default width.
package register_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : register_pkg

// File: rtl/register_bit.sv
// register_bit: one bit of storage with load enable and asynchronous
// active-high reset to a per-bit value.
//   clk    - clock, captures on rising edge
//   rst_   - asynchronous reset, active-high (forces q to RESET_BIT)
//   enable - 1 = capture d on the next rising clk
//   d      - data bit
//   q      - stored bit, straight from the flop
module register_bit
  import register_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_,
  input  logic enable,
  input  logic d,
  output logic q
);

  // RESET_BIT picks between a clear and a preset flop for this bit.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      q <= RESET_BIT;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : register_bit

// File: rtl/register.sv
// register: WIDTH-bit clock-enabled storage register with asynchronous,
// active-high reset to RESET_VAL. Used as an operand latch / accumulator
// store / pipeline holding register.
//   clk    - clock, all loads on the rising edge
//   rst_   - asynchronous reset, active-high despite the trailing underscore
//   enable - 1 = capture data on the next rising clk, 0 = hold
//   data   - word to store (don't-care while holding)
//   out    - stored word, driven directly from flops
module register
  import register_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("register: WIDTH=%0d is outside the supported range 1..64", WIDTH);
    end
  endgenerate

  // One flop per bit so each bit can reset to its own RESET_VAL bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      register_bit #(
        .RESET_BIT (RESET_VAL[gi])
      ) u_bit (
        .clk    (clk),
        .rst_   (rst_),
        .enable (enable),
        .d      (data[gi]),
        .q      (out[gi])
      );
    end
  endgenerate

  // ------------------------------------------------------------------
  // Behavioural checks. These registers have no fanout into the design
  // and are removed by synthesis.
  //
  // At each rising edge out of reset, chk_exp remembers what out must
  // hold after that edge (data when loading, current out when holding).
  // The next edge reads out before its own update and compares. Any
  // reset assertion in between cancels the pending check, and nothing is
  // checked until the register has been reset at least once (power-up
  // contents are undefined).
  // ------------------------------------------------------------------
  logic             chk_seen_reset;
  logic             chk_valid;
  logic [WIDTH-1:0] chk_exp;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      chk_seen_reset <= 1'b1;
      chk_valid      <= 1'b0;
      chk_exp        <= RESET_VAL;
    end else begin
      if (chk_valid) begin
        assert (out == chk_exp)
        else $error("register: load/hold violation, out=%h expected %h", out, chk_exp);
      end
      chk_exp   <= enable ? data : out;
      chk_valid <= chk_seen_reset;
    end
  end

  // Sampled mid-cycle so a reset raised at a clock edge has settled.
  always @(negedge clk) begin
    if (rst_) begin
      assert (out == RESET_VAL)
      else $error("register: out=%h under reset, expected %h", out, RESET_VAL);
    end
  end

endmodule : register

// File: tb/tb_register.sv
module tb_register;

  logic        clk;
  logic        rst8, en8;
  logic [7:0]  data8, out8;
  logic        rst16, en16;
  logic [15:0] data16, out16;

  register dut8 (
    .clk    (clk),
    .rst_   (rst8),
    .enable (en8),
    .data   (data8),
    .out    (out8)
  );

  register #(
    .WIDTH     (16),
    .RESET_VAL (16'hA5A5)
  ) dut16 (
    .clk    (clk),
    .rst_   (rst16),
    .enable (en16),
    .data   (data16),
    .out    (out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    bit          w16;
  } sb_t;

  sb_t         sb_q[$];
  int          total  = 0;
  int          passed = 0;
  logic [7:0]  model8;
  logic [15:0] model16;

  task automatic push(input string tag, input logic [15:0] exp, input bit w16);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    e.w16 = w16;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    sb_t         e;
    logic [15:0] obs;
    e   = sb_q.pop_front();
    obs = e.w16 ? out16 : {8'h00, out8};
    total++;
    assert (obs === e.exp) passed++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
  endtask

  task automatic check_all();
    while (sb_q.size() > 0) pop_check();
  endtask

  // Model: reset takes effect at once, a load at the next rising edge.
  task automatic drive8(input logic r, input logic e, input logic [7:0] d, input string tag);
    rst8  = r;
    en8   = e;
    data8 = d;
    if (r) model8 = 8'h00;
    else if (e === 1'b1) model8 = d;
    push(tag, {8'h00, model8}, 1'b0);
  endtask

  task automatic drive16(input logic r, input logic e, input logic [15:0] d, input string tag);
    rst16  = r;
    en16   = e;
    data16 = d;
    if (r) model16 = 16'hA5A5;
    else if (e === 1'b1) model16 = d;
    push(tag, model16, 1'b1);
  endtask

  // Inputs change 2 time units after a rising edge, outputs are checked
  // 1 time unit after it.
  task automatic edge_check();
    @(posedge clk);
    #1;
    check_all();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst8   = 1'b0;
    en8    = 1'bx;
    data8  = 'x;
    rst16  = 1'b0;
    en16   = 1'b0;
    data16 = '0;

    // Power-up cycle with no reset: contents undefined, nothing to check.
    @(posedge clk);
    #1;

    // Asynchronous reset, visible before any clock edge.
    #1;
    drive8(1'b1, 1'bx, 'x, "rst_async8");
    drive16(1'b1, 1'b0, 16'h0000, "rst_async16");
    #1;
    check_all();

    drive8(1'b1, 1'b1, 8'hFF, "rst_held_en8");
    edge_check();

    drive8(1'b0, 1'b0, 'x, "hold_x_after_release");
    drive16(1'b0, 1'b1, 16'h1234, "load16_1234");
    edge_check();

    drive8(1'b0, 1'b1, 8'hAA, "load_aa");
    drive16(1'b0, 1'b0, 16'hFFFF, "hold16_1234");
    edge_check();

    drive8(1'b0, 1'b0, 8'h55, "hold_aa");
    edge_check();

    // Reset raised mid-cycle clears at once and holds across an edge.
    #1;
    drive8(1'b1, 1'bx, 'x, "rst_mid_cycle");
    #1;
    check_all();
    drive8(1'b1, 1'bx, 'x, "rst_mid_edge");
    edge_check();

    drive8(1'b0, 1'b0, 'x, "hold_after_rst_mid");
    edge_check();

    drive8(1'b0, 1'b1, 8'h55, "load_55");
    edge_check();

    drive8(1'b0, 1'b0, 8'hAA, "hold_55");
    edge_check();

    // Reset coincident with a rising edge while loading: reset wins.
    en8    = 1'b1;
    data8  = 8'hFF;
    en16   = 1'b1;
    data16 = 16'hFFFF;
    @(posedge clk);
    rst8    = 1'b1;
    rst16   = 1'b1;
    model8  = 8'h00;
    model16 = 16'hA5A5;
    push("rst_coincident8", {8'h00, model8}, 1'b0);
    push("rst_coincident16", model16, 1'b1);
    #1;
    check_all();
    #1;

    drive8(1'b1, 1'b0, 'x, "rst_coinc_hold8");
    drive16(1'b1, 1'b0, 16'h0000, "rst_coinc_hold16");
    edge_check();

    drive8(1'b0, 1'b1, 8'h3C, "load_3c");
    drive16(1'b0, 1'b1, 16'h5A5A, "load16_5a5a");
    edge_check();

    drive8(1'b0, 1'b0, 8'hC3, "hold_3c");
    drive16(1'b0, 1'b0, 16'h0F0F, "hold16_5a5a");
    edge_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_register
